// File: rtl/div23_seq_if.sv
// Handshake bundle for div23_seq: dividend in on a valid/ready pair, and
// quotient plus remainder out on a valid/ready pair.
interface div23_seq_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic [DW-1:0] in_x;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_q;
    logic [4:0]    out_r;

    // Producer/consumer side (drives the dividend, takes the result)
    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_q, out_r
    );

    // Divider side
    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_q, out_r
    );
endinterface

// File: rtl/div23_seq.sv
// Sequential unsigned divide-by-23, radix 4: two dividend bits per BUSY cycle,
// quotient digit and remainder from a compare-subtract against 23/46/69.
module div23_seq #(
    parameter int DW = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    div23_seq_if.slave  bus
);
    localparam int STEPS = DW / 2;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] shreg;
    logic [DW-1:0] quo;
    logic [4:0]    rem;
    logic [CW-1:0] cnt;
    logic          live;
    logic          accept;
    logic          last;
    logic [6:0]    stp;

    // Returns {digit[1:0], new_rem[4:0]} for t = 4*r + d, with r <= 22 so t <= 91.
    function automatic logic [6:0] div_step(input logic [4:0] r, input logic [1:0] d);
        logic [6:0] t;
        logic [6:0] rn;
        logic [1:0] qd;
        t = {r, d};
        if (t >= 7'd69) begin
            qd = 2'd3;
            rn = t - 7'd69;
        end else if (t >= 7'd46) begin
            qd = 2'd2;
            rn = t - 7'd46;
        end else if (t >= 7'd23) begin
            qd = 2'd1;
            rn = t - 7'd23;
        end else begin
            qd = 2'd0;
            rn = t;
        end
        return {qd, rn[4:0]};
    endfunction

    assign stp    = div_step(rem, shreg[DW-1 -: 2]);
    assign last   = (cnt == CW'(STEPS - 1));
    assign accept = bus.in_ready && bus.in_valid;

    // live holds in_ready low while reset is asserted, even though state is IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = live;
                if (live && bus.in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= bus.in_x;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else if (state == BUSY) begin
            shreg <= shreg << 2;
            quo   <= (quo << 2) | DW'(stp[6:5]);
            rem   <= stp[4:0];
            cnt   <= cnt + CW'(1);
        end
    end

    assign bus.out_q = quo;
    assign bus.out_r = rem;
endmodule

// File: tb/tb_div23_seq.sv
// Directed and exhaustive checks for div23_seq (DW=16); the sweep runs on
// parallel lanes sharing clock and reset.
module tb_div23_seq;
    localparam int DW    = 16;
    localparam int LANES = 32;
    localparam int PER   = 65536 / LANES;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    div23_seq_if #(.DW(DW)) bus ();

    div23_seq #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [DW-1:0]    sw_x [LANES];
    logic             sw_valid;
    logic [DW-1:0]    sw_q [LANES];
    logic [4:0]       sw_r [LANES];
    logic [LANES-1:0] sw_ov;
    logic [LANES-1:0] sw_ir;

    for (genvar g = 0; g < LANES; g++) begin : lane
        div23_seq_if #(.DW(DW)) sif ();
        assign sif.in_valid  = sw_valid;
        assign sif.in_x      = sw_x[g];
        assign sif.out_ready = 1'b1;
        assign sw_q[g]       = sif.out_q;
        assign sw_r[g]       = sif.out_r;
        assign sw_ov[g]      = sif.out_valid;
        assign sw_ir[g]      = sif.in_ready;
        div23_seq #(.DW(DW)) u (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sif.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus only: waits for in_ready, launches x, returns latency (-1 on timeout).
    task automatic run_op(input logic [DW-1:0] x, output int lat,
                          output logic [DW-1:0] q, output logic [4:0] r);
        lat = -1;
        q   = '0;
        r   = '0;
        for (int w = 0; w < 20 && !bus.in_ready; w++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.out_valid) begin
                lat = c;
                q   = bus.out_q;
                r   = bus.out_r;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b1;
        sw_valid      = 1'b0;
        for (int g = 0; g < LANES; g++) sw_x[g] = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_checks++;
        if (bus.out_q !== 16'd0 || bus.out_r !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got q=%0d r=%0d expected q=0 r=0", bus.out_q, bus.out_r);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_values();
        logic [DW-1:0] xs [5] = '{16'd0, 16'd22, 16'd23, 16'd1000, 16'd65535};
        logic [DW-1:0] eq [5] = '{16'd0, 16'd0, 16'd1, 16'd43, 16'd2849};
        logic [4:0]    er [5] = '{5'd0, 5'd22, 5'd0, 5'd11, 5'd8};
        int            lat;
        logic [DW-1:0] q;
        logic [4:0]    r;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_op(xs[i], lat, q, r);
            n_checks++;
            if (lat !== 9) begin
                n_fail++;
                $display("FAIL value_latency x=%0d: got %0d expected 9", xs[i], lat);
            end
            n_checks++;
            if (q !== eq[i]) begin
                n_fail++;
                $display("FAIL value_q x=%0d: got %0d expected %0d", xs[i], q, eq[i]);
            end
            n_checks++;
            if (r !== er[i]) begin
                n_fail++;
                $display("FAIL value_r x=%0d: got %0d expected %0d", xs[i], r, er[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit got;
        bit rdy_seen;
        got      = 1'b0;
        rdy_seen = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 20 && !bus.in_ready; w++) @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_x      = 16'd46;
        @(posedge clk);
        @(negedge clk);
        bus.in_x = 16'd100;
        for (int c = 0; c < 20; c++) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!got || bus.out_q !== 16'd2 || bus.out_r !== 5'd0) begin
            n_fail++;
            $display("FAIL bp_result: got valid=%b q=%0d r=%0d expected 1, q=2 r=0",
                     got, bus.out_q, bus.out_r);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.in_ready) rdy_seen = 1'b1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_q !== 16'd2 || bus.out_r !== 5'd0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got valid=%b q=%0d r=%0d expected 1, q=2 r=0",
                         k, bus.out_valid, bus.out_q, bus.out_r);
            end
        end
        n_checks++;
        if (rdy_seen) begin
            n_fail++;
            $display("FAIL bp_in_ready: got in_ready=1 while busy/done expected 0");
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [4] = '{16'd5, 16'd500, 16'd2307, 16'd65534};
        logic [DW-1:0] eq [4]   = '{16'd0, 16'd21, 16'd100, 16'd2849};
        logic [4:0]    er [4]   = '{5'd5, 5'd17, 5'd7, 5'd7};
        int            acc_t [4];
        logic [DW-1:0] rq [4];
        logic [4:0]    rr [4];
        int            na;
        int            nr;
        na = 0;
        nr = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            acc_t[i] = 0;
            rq[i]    = '0;
            rr[i]    = '0;
        end
        for (int cyc = 0; cyc < 100 && nr < 4; cyc++) begin
            if (na < 4) begin
                bus.in_valid = 1'b1;
                bus.in_x     = vals[na];
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.in_ready && na < 4) begin
                acc_t[na] = cyc;
                na++;
            end
            if (bus.out_valid) begin
                rq[nr] = bus.out_q;
                rr[nr] = bus.out_r;
                nr++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (nr != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results expected 4", nr);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (acc_t[i+1] - acc_t[i] != DW / 2 + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing %0d: got %0d expected %0d",
                         i, acc_t[i+1] - acc_t[i], DW / 2 + 2);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rq[i] !== eq[i] || rr[i] !== er[i]) begin
                n_fail++;
                $display("FAIL b2b_result %0d: got q=%0d r=%0d expected q=%0d r=%0d",
                         i, rq[i], rr[i], eq[i], er[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit            saw;
        int            lat;
        logic [DW-1:0] q;
        logic [4:0]    r;
        saw = 1'b0;
        bus.out_ready = 1'b1;
        for (int w = 0; w < 20 && !bus.in_ready; w++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = 16'd1000;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_q !== 16'd0 || bus.out_r !== 5'd0) begin
            n_fail++;
            $display("FAIL midreset_async: got rdy=%b vld=%b q=%0d r=%0d expected all 0",
                     bus.in_ready, bus.out_valid, bus.out_q, bus.out_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.out_valid) saw = 1'b1;
        end
        n_checks++;
        if (saw) begin
            n_fail++;
            $display("FAIL midreset_no_valid: got out_valid=1 expected none");
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b expected 1", bus.in_ready);
        end
        run_op(16'd1000, lat, q, r);
        n_checks++;
        if (lat !== 9 || q !== 16'd43 || r !== 5'd11) begin
            n_fail++;
            $display("FAIL midreset_next: got lat=%0d q=%0d r=%0d expected 9, 43, 11", lat, q, r);
        end
    endtask

    task automatic test_sweep();
        int  shown;
        bit  done;
        int  x;
        int  q;
        int  r;
        shown = 0;
        @(negedge clk);
        for (int i = 0; i < PER; i++) begin
            for (int w = 0; w < 20 && sw_ir != {LANES{1'b1}}; w++) @(negedge clk);
            for (int g = 0; g < LANES; g++) sw_x[g] = DW'(g * PER + i);
            sw_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            sw_valid = 1'b0;
            done = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                if (sw_ov == {LANES{1'b1}}) begin
                    done = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!done) begin
                n_checks++;
                n_fail++;
                $display("FAIL sweep_timeout at i=%0d: out_valid=%h expected all ones", i, sw_ov);
                break;
            end
            for (int g = 0; g < LANES; g++) begin
                x = g * PER + i;
                q = int'(sw_q[g]);
                r = int'(sw_r[g]);
                n_checks++;
                if (q * 23 + r != x || r >= 23 || q != x / 23 || r != x % 23) begin
                    n_fail++;
                    if (shown < 10) begin
                        shown++;
                        $display("FAIL sweep x=%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                                 x, q, r, x / 23, x % 23);
                    end
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_values();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
